// File: rtl/ysyx_22040088_ex_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22040088_ex_stage
//   Single-entry execute stage: one ALU between the decode handshake and a
//   registered result, plus a combinational forward of the held result.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     in_valid / in_ready      decode-side handshake
//     in_pc, in_alu_control,   instruction payload (one-hot ALU op,
//     in_src1, in_src2,        operands, RV64 *W flag, destination)
//     in_word_op, in_rd,
//     in_rf_we
//     flush                    drop held and offered instruction
//     out_valid / out_ready    writeback-side handshake
//     out_pc, out_result,      registered payload
//     out_rd, out_rf_we
//     fwd_valid, fwd_rd,       forward of the held result for operand bypass
//     fwd_result
//
// ysyx_22040088_ALU
//   Combinational 64-bit ALU with one-hot op select. Each op result is masked
//   by its select bit and OR-ed together, so an all-zero select yields 0.
//   lui returns src2 unchanged (the immediate arrives pre-shifted).
// ---------------------------------------------------------------------------

module ysyx_22040088_ALU (
  input  logic [10:0] alu_control,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic [63:0] result
);

  logic        op_add, op_sub, op_slt, op_sltu, op_and, op_or, op_xor;
  logic        op_sll, op_srl, op_sra, op_lui;
  logic        do_sub;
  logic [63:0] b_in;
  logic [64:0] sum_ext;
  logic [63:0] sum;
  logic        lt_s, lt_u;
  logic [5:0]  shamt;
  logic [63:0] sll_r, srl_r, sra_r;

  assign {op_lui, op_sra, op_srl, op_sll, op_xor, op_or,
          op_and, op_sltu, op_slt, op_sub, op_add} = alu_control;

  // Compares share the subtractor with sub.
  assign do_sub  = op_sub | op_slt | op_sltu;
  assign b_in    = do_sub ? ~src2 : src2;
  assign sum_ext = {1'b0, src1} + {1'b0, b_in} + {64'd0, do_sub};
  assign sum     = sum_ext[63:0];

  // Unsigned borrow is the inverted carry-out; signed compare only needs the
  // difference sign when operand signs agree (no overflow possible then).
  assign lt_u = ~sum_ext[64];
  assign lt_s = (src1[63] ^ src2[63]) ? src1[63] : sum[63];

  assign shamt = src2[5:0];
  assign sll_r = src1 << shamt;
  assign srl_r = src1 >> shamt;
  assign sra_r = $signed(src1) >>> shamt;

  assign result = ({64{op_add | op_sub}} & sum)
                | ({64{op_slt}}          & {63'd0, lt_s})
                | ({64{op_sltu}}         & {63'd0, lt_u})
                | ({64{op_and}}          & (src1 & src2))
                | ({64{op_or}}           & (src1 | src2))
                | ({64{op_xor}}          & (src1 ^ src2))
                | ({64{op_sll}}          & sll_r)
                | ({64{op_srl}}          & srl_r)
                | ({64{op_sra}}          & sra_r)
                | ({64{op_lui}}          & src2);

endmodule

module ysyx_22040088_ex_stage #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [10:0] in_alu_control,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic        in_word_op,
  input  logic [4:0]  in_rd,
  input  logic        in_rf_we,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_rf_we,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [63:0] fwd_result
);

  logic        word_ok;
  logic        is_sll, is_srl, is_sra, is_shift;
  logic [63:0] alu_src1, alu_src2, alu_res, res_final;
  logic        accept;

  logic        vld_q;
  logic [63:0] pc_q, res_q;
  logic [4:0]  rd_q;
  logic        we_q;

  assign is_sll   = in_alu_control[7];
  assign is_srl   = in_alu_control[8];
  assign is_sra   = in_alu_control[9];
  assign is_shift = is_sll | is_srl | is_sra;

  // *W semantics only exist for add/sub/shifts; the flag is dropped otherwise.
  assign word_ok = in_word_op & (in_alu_control[0] | in_alu_control[1] | is_shift);

  // 32-bit shifts reuse the 64-bit shifter: right shifts need the upper half
  // prepared (zero for logical, sign for arithmetic) and shamt limited to 5 bits.
  always_comb begin
    alu_src1 = in_src1;
    alu_src2 = in_src2;
    if (word_ok) begin
      if (is_srl) alu_src1 = {32'd0, in_src1[31:0]};
      if (is_sra) alu_src1 = {{32{in_src1[31]}}, in_src1[31:0]};
      if (is_shift) alu_src2 = {59'd0, in_src2[4:0]};
    end
  end

  ysyx_22040088_ALU u_alu (
    .alu_control (in_alu_control),
    .src1        (alu_src1),
    .src2        (alu_src2),
    .result      (alu_res)
  );

  assign res_final = word_ok ? {{32{alu_res[31]}}, alu_res[31:0]} : alu_res;

  assign in_ready = ~vld_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      pc_q  <= 64'd0;
      res_q <= 64'd0;
      rd_q  <= 5'd0;
      we_q  <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      pc_q  <= in_pc;
      res_q <= res_final;
      rd_q  <= in_rd;
      // x0 is never written; killing the enable here keeps bypass clean too.
      we_q  <= in_rf_we & (|in_rd);
    end else if (vld_q & out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid  = vld_q;
  assign out_pc     = pc_q;
  assign out_result = res_q;
  assign out_rd     = rd_q;
  assign out_rf_we  = vld_q & we_q;

  assign fwd_valid  = BYPASS_EN & out_rf_we;
  assign fwd_rd     = rd_q;
  assign fwd_result = res_q;

endmodule

// File: tb/tb_ysyx_22040088_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040088_ex_stage
//   Scoreboard bench: a negedge monitor models the single-entry register as a
//   queue (size 0 or 1), pushes the expected result on accept and compares
//   when the held entry drains. Directed sequences cover reset, word ops,
//   stall, flush, reset mid-stall and a BYPASS_EN=0 instance.
// ---------------------------------------------------------------------------
module tb_ysyx_22040088_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_pc = 64'd0;
  logic [10:0] in_alu_control = 11'd0;
  logic [63:0] in_src1 = 64'd0, in_src2 = 64'd0;
  logic        in_word_op = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_rf_we = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_rf_we, fwd_valid;
  logic [63:0] out_pc, out_result, fwd_result;
  logic [4:0]  out_rd, fwd_rd;

  logic        in_ready_nb, out_valid_nb, out_rf_we_nb, fwd_valid_nb;
  logic [63:0] out_pc_nb, out_result_nb, fwd_result_nb;
  logic [4:0]  out_rd_nb, fwd_rd_nb;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;
  exp_t sb[$];

  localparam logic [10:0] ADD = 11'h001, SUB = 11'h002, SLT = 11'h004, SLTU = 11'h008,
                          AND = 11'h010, OR  = 11'h020, XOR = 11'h040, SLL  = 11'h080,
                          SRL = 11'h100, SRA = 11'h200, LUI = 11'h400;

  always #5 clk = ~clk;

  ysyx_22040088_ex_stage #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_alu_control(in_alu_control), .in_src1(in_src1), .in_src2(in_src2),
    .in_word_op(in_word_op), .in_rd(in_rd), .in_rf_we(in_rf_we), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_result(out_result), .out_rd(out_rd), .out_rf_we(out_rf_we),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result)
  );

  ysyx_22040088_ex_stage #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nb), .in_pc(in_pc),
    .in_alu_control(in_alu_control), .in_src1(in_src1), .in_src2(in_src2),
    .in_word_op(in_word_op), .in_rd(in_rd), .in_rf_we(in_rf_we), .flush(flush),
    .out_valid(out_valid_nb), .out_ready(out_ready), .out_pc(out_pc_nb),
    .out_result(out_result_nb), .out_rd(out_rd_nb), .out_rf_we(out_rf_we_nb),
    .fwd_valid(fwd_valid_nb), .fwd_rd(fwd_rd_nb), .fwd_result(fwd_result_nb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [10:0] c, input logic [63:0] a,
                                        input logic [63:0] b, input logic w);
    logic [31:0] r32;
    logic [63:0] r;
    r32 = 32'd0;
    r   = 64'd0;
    if (w && (c == ADD || c == SUB || c == SLL || c == SRL || c == SRA)) begin
      case (c)
        ADD:     r32 = a[31:0] + b[31:0];
        SUB:     r32 = a[31:0] - b[31:0];
        SLL:     r32 = a[31:0] << b[4:0];
        SRL:     r32 = a[31:0] >> b[4:0];
        default: r32 = 32'($signed(a[31:0]) >>> b[4:0]);
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (c)
        ADD:     r = a + b;
        SUB:     r = a - b;
        SLT:     r = {63'd0, $signed(a) < $signed(b)};
        SLTU:    r = {63'd0, a < b};
        AND:     r = a & b;
        OR:      r = a | b;
        XOR:     r = a ^ b;
        SLL:     r = a << b[5:0];
        SRL:     r = a >> b[5:0];
        SRA:     r = 64'($signed(a) >>> b[5:0]);
        LUI:     r = b;
        default: r = 64'd0;
      endcase
    end
    return r;
  endfunction

  // Monitor: decisions made here take effect at the following rising edge.
  always @(negedge clk) begin
    logic mready;
    exp_t e;
    mready = (sb.size() == 0) || out_ready;
    if (!rst) begin
      chk("out_valid_vs_model", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      chk("in_ready_vs_model", {63'd0, in_ready}, {63'd0, mready});
    end
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && out_ready) begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_result", out_result, e.res);
        chk("sb_rd", {59'd0, out_rd}, {59'd0, e.rd});
        chk("sb_rf_we", {63'd0, out_rf_we}, {63'd0, e.we});
        chk("sb_fwd_valid", {63'd0, fwd_valid}, {63'd0, e.we});
        if (e.we) begin
          chk("sb_fwd_rd", {59'd0, fwd_rd}, {59'd0, e.rd});
          chk("sb_fwd_result", fwd_result, e.res);
        end
      end
      if (in_valid && mready) begin
        e.pc  = in_pc;
        e.res = model(in_alu_control, in_src1, in_src2, in_word_op);
        e.rd  = in_rd;
        e.we  = in_rf_we && (in_rd != 5'd0);
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [10:0] c, input logic [63:0] a, input logic [63:0] b,
                    input logic w, input logic [4:0] rd, input logic we);
    in_valid       = 1'b1;
    in_pc          = in_pc + 64'd4;
    in_alu_control = c;
    in_src1        = a;
    in_src2        = b;
    in_word_op     = w;
    in_rd          = rd;
    in_rf_we       = we;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    // Reset, with an instruction offered during reset that must not land.
    tick(); tick();
    op(ADD, 64'd1, 64'd2, 1'b0, 5'd1, 1'b1);
    tick();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_rf_we", {63'd0, out_rf_we}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    idle(); rst = 1'b0;
    tick();

    // or -> 0xFF, forwarded; the BYPASS_EN=0 copy holds it but never forwards.
    op(OR, 64'hF0, 64'h0F, 1'b0, 5'd5, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("or_result", out_result, 64'hFF);
    chk("or_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    chk("nb_out_valid", {63'd0, out_valid_nb}, 64'd1);
    chk("nb_fwd_valid", {63'd0, fwd_valid_nb}, 64'd0);
    tick();

    // Directed ALU patterns, back to back at full throughput.
    op(SLL, 64'h1, 64'h3F, 1'b1, 5'd6, 1'b1);                     tick();
    op(SRL, 64'hFFFFFFFF_80000000, 64'd1, 1'b1, 5'd7, 1'b1);       tick();
    op(SRA, 64'hFFFFFFFF_80000000, 64'd1, 1'b1, 5'd8, 1'b1);       tick();
    op(ADD, 64'h7FFFFFFF, 64'd1, 1'b1, 5'd9, 1'b1);                tick();
    op(SUB, 64'd0, 64'd1, 1'b1, 5'd10, 1'b1);                      tick();
    op(SUB, 64'd5, 64'd7, 1'b0, 5'd11, 1'b1);                      tick();
    op(SLT, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 5'd12, 1'b1);      tick();
    op(SLTU, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 5'd13, 1'b1);     tick();
    op(SRA, 64'h80000000_00000000, 64'd63, 1'b0, 5'd14, 1'b1);     tick();
    op(SLL, 64'h1, 64'h3F, 1'b0, 5'd15, 1'b1);                     tick();
    op(AND, 64'hFFFF0000_FFFF0000, 64'h12345678_9ABCDEF0, 1'b1, 5'd16, 1'b1); tick();
    op(LUI, 64'd0, 64'hFFFFFFFF_FFFFF000, 1'b0, 5'd17, 1'b1);      tick();
    op(11'd0, 64'd3, 64'd4, 1'b0, 5'd18, 1'b1);                    tick();
    op(XOR, 64'd3, 64'd4, 1'b0, 5'd0, 1'b1);                       tick();
    idle(); tick();

    // Stall: A held while out_ready=0, B waits, then both delivered in order.
    out_ready = 1'b0;
    op(XOR, 64'hAAAA, 64'h5555, 1'b0, 5'd20, 1'b1);
    tick();
    op(XOR, 64'h1234, 64'h00FF, 1'b0, 5'd21, 1'b1);
    @(negedge clk);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_result", out_result, 64'hFFFF);
    held = out_result;
    tick();
    @(negedge clk);
    chk("stall_hold", out_result, held);
    chk("stall_rd", {59'd0, out_rd}, 64'd20);
    tick();
    out_ready = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("stall_second", out_result, 64'h12CB);
    tick();

    // Flush with a valid held result and a valid offer.
    out_ready = 1'b0;
    op(OR, 64'h1, 64'h2, 1'b0, 5'd22, 1'b1);
    tick();
    op(ADD, 64'h1, 64'h2, 1'b0, 5'd23, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_rf_we", {63'd0, out_rf_we}, 64'd0);
    chk("flush_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    out_ready = 1'b1;
    tick();

    // Reset while stalled with a valid result and a pending offer.
    out_ready = 1'b0;
    op(OR, 64'h10, 64'h20, 1'b0, 5'd3, 1'b1);
    tick();
    op(ADD, 64'h5, 64'h6, 1'b0, 5'd4, 1'b1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_out_result", out_result, 64'd0);
    chk("rst2_out_pc", out_pc, 64'd0);
    chk("rst2_out_rd", {59'd0, out_rd}, 64'd0);
    chk("rst2_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    rst = 1'b0;
    idle();
    out_ready = 1'b1;
    tick();

    // Random traffic with random backpressure; scoreboard does the checking.
    for (int i = 0; i < 60; i++) begin
      logic [10:0] c;
      c = 11'd1 << $urandom_range(0, 11);
      if ($urandom_range(0, 3) != 0)
        op(c, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else
        idle();
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      @(negedge clk);
      chk("nb_fwd_never", {63'd0, fwd_valid_nb}, 64'd0);
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_ex_stage.md
YSYX_22040088_EX_STAGE -- requirements
Module: ysyx_22040088_ex_stage

Interface
REQ-001 Parameter: BYPASS_EN, default 1, when 1 drives the combinational forwarding outputs; when 0 ties fwd_valid to 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  decode stage presents a valid instruction.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_pc  input  64  instruction PC, carried through.
REQ-007 in_alu_control  input  11  one-hot ALU op: bit0 add, bit1 sub, bit2 slt, bit3 sltu, bit4 and, bit5 or, bit6 xor, bit7 sll, bit8 srl, bit9 sra, bit10 lui.
REQ-008 in_src1, in_src2  input  64 each  ALU operands.
REQ-009 in_word_op  input  1  RV64 *W instruction (addw/subw/sllw/srlw/sraw/addiw/slliw/srliw/sraiw).
REQ-010 in_rd  input  5  destination register index.
REQ-011 in_rf_we  input  1  instruction writes rd.
REQ-012 flush  input  1  discard the held instruction and any instruction offered this cycle.
REQ-013 out_valid  output  1  result register holds a valid instruction.
REQ-014 out_ready  input  1  downstream consumes the result.
REQ-015 out_pc  output  64; out_result  output  64; out_rd  output  5; out_rf_we  output  1 -- registered payload.
REQ-016 fwd_valid  output  1; fwd_rd  output  5; fwd_result  output  64 -- combinational forward of the held result.

Function
REQ-017 The stage SHALL instantiate ysyx_22040088_ALU once, combinationally between the input port and the output register.
REQ-018 Operand prep, in_word_op=0: ALU src1/src2 = in_src1/in_src2 unmodified.
REQ-019 Operand prep, in_word_op=1: src1 = zero-extended in_src1[31:0] for srl, sign-extended in_src1[31:0] for sra, in_src1 otherwise; src2 = {59'b0, in_src2[4:0]} for sll/srl/sra, in_src2 otherwise.
REQ-020 Result, in_word_op=1: stored result = sign-extension of ALU result[31:0]; in_word_op=0: stored result = ALU result unmodified.
REQ-021 in_word_op with any op other than add/sub/sll/srl/sra SHALL be ignored (treated as 0).
REQ-022 in_alu_control all-zero SHALL store result 0; in_rf_we still passes through.
REQ-023 Handshake: in_ready = ~out_valid | out_ready (combinational, single-entry pipeline register, full throughput).
REQ-024 Accept = in_valid & in_ready & ~flush; on accept, payload and result SHALL load next edge and out_valid SHALL be 1; latency exactly 1 cycle.
REQ-025 Drain: out_valid & out_ready without accept SHALL clear out_valid next edge; simultaneous drain and accept SHALL replace the payload with out_valid staying 1.
REQ-026 Stall: out_valid & ~out_ready SHALL hold all out_* stable; in_ready=0.
REQ-027 Flush SHALL clear out_valid next edge regardless of out_ready or in_valid; flush dominates accept.
REQ-028 out_rf_we SHALL be forced to 0 whenever out_valid=0; out_rd=0 forces out_rf_we=0.
REQ-029 fwd_valid = BYPASS_EN & out_valid & out_rf_we; fwd_rd = out_rd; fwd_result = out_result.
REQ-030 Payload registers SHALL NOT load when no accept occurs.

Reset
REQ-031 rst=1 at an edge SHALL set out_valid=0, out_rf_we=0, out_pc=0, out_result=0, out_rd=0; reset dominates flush and accept.
REQ-032 During rst=1, in_ready SHALL read 1 (out_valid=0) but no instruction SHALL be captured; reset mid-stall drops the held instruction.

Verification
REQ-033 or, src1=0xF0, src2=0x0F, rd=5, rf_we=1, out_ready=1 -> next cycle out_valid=1, out_result=0xFF, out_rd=5, fwd_valid=1.
REQ-034 sll word_op=1, src1=0x1, src2=0x3F -> shamt 31, out_result=0xFFFFFFFF80000000.
REQ-035 srl word_op=1, src1=0xFFFFFFFF_80000000, src2=1 -> out_result=0x0000000040000000; sra same operands -> 0xFFFFFFFFC0000000.
REQ-036 Back-to-back xor ops with out_ready=0 on cycle 2 -> in_ready=0, first result held unchanged; out_ready=1 on cycle 3 -> second result appears cycle 4, none lost or duplicated.
REQ-037 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, out_rf_we=0, fwd_valid=0, offered instruction not captured.
REQ-038 rst asserted while stalled with valid result -> next cycle all outputs 0; BYPASS_EN=0 build -> fwd_valid constant 0.
